// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered sync, strobes and colouriser.
// All outputs are computed from the pre-increment counter position on each pixel tick.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 1,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pixval,
    input  logic [1:0]       mode,
    input  logic [3*CW-1:0]  fg_color,
    input  logic [3*CW-1:0]  bg_color,
    output logic [CNT_W-1:0] xpix,
    output logic [CNT_W-1:0] ypix,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             line_start,
    output logic             frame_start,
    output logic [3*CW-1:0]  rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    logic [1:0]       mode_q;
    logic [2:0]       bar_q;
    logic [CNT_W-1:0] bcnt_q;

    logic             x_end;
    logic             y_end;
    logic             vis;
    logic             hs_on;
    logic             vs_on;
    logic [3*CW-1:0]  bar_rgb;
    logic [3*CW-1:0]  pix_rgb;

    always_comb begin
        x_end   = (xpix == X_LAST);
        y_end   = (ypix == Y_LAST);
        vis     = (xpix < X_VIS) && (ypix < Y_VIS);
        hs_on   = (xpix >= HS_BEG) && (xpix < HS_END);
        vs_on   = (ypix >= VS_BEG) && (ypix < VS_END);
        bar_rgb = {{CW{bar_q[2]}}, {CW{bar_q[1]}}, {CW{bar_q[0]}}};
        pix_rgb = '0;
        unique case (mode_q)
            2'd0: pix_rgb = pixval ? fg_color : bg_color;
            2'd1: pix_rgb = pixval ? bg_color : fg_color;
            2'd2: pix_rgb = fg_color;
            2'd3: pix_rgb = bar_rgb;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpix        <= '0;
            ypix        <= '0;
            mode_q      <= '0;
            bar_q       <= '0;
            bcnt_q      <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            rgb         <= '0;
        end else if (en) begin
            xpix <= x_end ? '0 : xpix + 1'b1;
            if (x_end) begin
                ypix <= y_end ? '0 : ypix + 1'b1;
            end
            hsync       <= hs_on ? HS_POL : ~HS_POL;
            vsync       <= vs_on ? VS_POL : ~VS_POL;
            active      <= vis;
            line_start  <= (xpix == '0);
            frame_start <= (xpix == '0) && (ypix == '0);
            rgb         <= vis ? pix_rgb : '0;
            if (x_end && y_end) begin
                mode_q <= mode;
            end
            // bar_q tracks the bar of the next pixel; stays at 7 past the last full bar
            if (x_end) begin
                bar_q  <= '0;
                bcnt_q <= '0;
            end else if (bcnt_q == BAR_LAST) begin
                bcnt_q <= '0;
                if (bar_q != 3'd7) begin
                    bar_q <= bar_q + 1'b1;
                end
            end else begin
                bcnt_q <= bcnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised scoreboard bench for vga_timing_gen on a reduced raster.
// Expected outputs come from tick-count arithmetic over the raster geometry.
module tb_vga_timing_gen;

    localparam int HA = 20, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 6, VF = 1, VSW = 2, VB = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam bit HSP = 1'b1;
    localparam bit VSP = 1'b0;
    localparam int CW = 2;
    localparam int CNT_W = 6;
    localparam int NCYC = 6000;

    typedef struct {
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
        logic             hs;
        logic             vs;
        logic             act;
        logic             ls;
        logic             fs;
        logic [3*CW-1:0]  rgb;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             pixval;
    logic [1:0]       mode;
    logic [3*CW-1:0]  fg_color;
    logic [3*CW-1:0]  bg_color;
    logic [CNT_W-1:0] xpix;
    logic [CNT_W-1:0] ypix;
    logic             hsync;
    logic             vsync;
    logic             active;
    logic             line_start;
    logic             frame_start;
    logic [3*CW-1:0]  rgb;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   running = 0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HSP), .VS_POL(VSP), .CW(CW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pixval(pixval),
        .mode(mode), .fg_color(fg_color), .bg_color(bg_color),
        .xpix(xpix), .ypix(ypix), .hsync(hsync), .vsync(vsync),
        .active(active), .line_start(line_start),
        .frame_start(frame_start), .rgb(rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] chan(input int b, input int k);
        return ((b >> k) & 1) != 0 ? {CW{1'b1}} : {CW{1'b0}};
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.x = '0; e.y = '0; e.hs = !HSP; e.vs = !VSP;
        e.act = 0; e.ls = 0; e.fs = 0; e.rgb = '0;
        return e;
    endfunction

    // n = pixel ticks since reset; outputs describe position n, counters move to n+1
    function automatic exp_t model(input int n, input logic pv, input logic [1:0] md,
                                   input logic [3*CW-1:0] fg, input logic [3*CW-1:0] bg);
        exp_t e;
        int x, y, b;
        x = n % HT;
        y = (n / HT) % VT;
        e.x = CNT_W'((n + 1) % HT);
        e.y = CNT_W'(((n + 1) / HT) % VT);
        e.hs = (x >= HA + HF && x < HA + HF + HSW) ? HSP : !HSP;
        e.vs = (y >= VA + VF && y < VA + VF + VSW) ? VSP : !VSP;
        e.act = (x < HA) && (y < VA);
        e.ls = (x == 0);
        e.fs = (x == 0) && (y == 0);
        b = x / (HA / 8);
        if (b > 7) b = 7;
        if (!e.act) e.rgb = '0;
        else if (md == 2'd0) e.rgb = pv ? fg : bg;
        else if (md == 2'd1) e.rgb = pv ? bg : fg;
        else if (md == 2'd2) e.rgb = fg;
        else e.rgb = {chan(b, 2), chan(b, 1), chan(b, 0)};
        return e;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (running) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("xpix", 32'(xpix), 32'(e.x));
                    chk("ypix", 32'(ypix), 32'(e.y));
                    chk("hsync", 32'(hsync), 32'(e.hs));
                    chk("vsync", 32'(vsync), 32'(e.vs));
                    chk("active", 32'(active), 32'(e.act));
                    chk("line_start", 32'(line_start), 32'(e.ls));
                    chk("frame_start", 32'(frame_start), 32'(e.fs));
                    chk("rgb", 32'(rgb), 32'(e.rgb));
                end
            end
        end
    end

    initial begin
        exp_t cur;
        int   n = 0;
        int   rst_cnt = 0;
        logic [1:0] mode_cur = 2'd0;
        int   x, y;

        rst_n = 1'b0; en = 1'b0; pixval = 1'b0; mode = 2'd0;
        fg_color = '0; bg_color = '0;
        cur = reset_exp();

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            if (c == 0) rst_cnt = 3;
            if (c == 2000 || c == 4777) rst_cnt = $urandom_range(1, 3);
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_n) begin
                    rst_n = 1'b0;
                    #1;
                    chk("async_rst_x", 32'(xpix), 32'd0);
                    chk("async_rst_y", 32'(ypix), 32'd0);
                    chk("async_rst_rgb", 32'(rgb), 32'd0);
                    chk("async_rst_hs", 32'(hsync), 32'(!HSP));
                    chk("async_rst_act", 32'(active), 32'd0);
                end
                rst_n = 1'b0;
                en = $urandom_range(0, 1);
                n = 0;
                mode_cur = 2'd0;
                cur = reset_exp();
            end else begin
                rst_n = 1'b1;
                pixval = $urandom_range(0, 1);
                fg_color = 6'($urandom);
                bg_color = 6'($urandom);
                if (c < 1000) begin
                    en = 1'b1;
                    mode = 2'd3;
                end else if (c < 4000) begin
                    en = $urandom_range(0, 1);
                    if ($urandom_range(0, 36) == 0) mode = 2'($urandom);
                end else begin
                    en = c[0];
                    if ($urandom_range(0, 50) == 0) mode = 2'($urandom);
                end
                if (en) begin
                    cur = model(n, pixval, mode_cur, fg_color, bg_color);
                    x = n % HT;
                    y = (n / HT) % VT;
                    if (x == HT - 1 && y == VT - 1) mode_cur = mode;
                    n++;
                end
            end
            q.push_back(cur);
            running = 1'b1;
        end

        @(posedge clk);
        #2;
        running = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
